dff: RTL and testbench
======================

DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits of i_d and o_q; legal range 1..64.
REQ-002 Parameter STAGES, default 1, number of register stages between i_d and o_q; legal range 1..16.
REQ-003 Parameter RESET_VALUE, default 0 (WIDTH bits), value loaded into every stage while reset is asserted.
REQ-004 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 i_d  input  WIDTH  data sampled on each rising edge of i_clk.
REQ-007 o_q  output  WIDTH  registered output, taken directly from the last stage.
REQ-008 The design SHALL have exactly one clock, and reset SHALL be asynchronous and active-low.

Function
REQ-009 The block SHALL implement a chain of STAGES registers, each WIDTH bits wide, clocked by i_clk.
REQ-010 On each rising i_clk edge with i_reset=1, stage 0 SHALL load i_d and stage k SHALL load stage k-1 for k=1..STAGES-1.
REQ-011 o_q SHALL equal the last stage, giving a latency of exactly STAGES rising edges from i_d to o_q.
REQ-012 With STAGES=1 the block SHALL act as a plain D flip-flop: o_q after edge n equals i_d sampled at edge n.
REQ-013 o_q SHALL be driven only by a register, with no combinational path from i_d or i_reset.
REQ-014 Each bit SHALL be independent, so no arithmetic, truncation or sign extension applies.
REQ-015 o_q SHALL change only on a rising i_clk edge or on assertion of reset, and SHALL not change on falling edges or on i_d changes between edges.
REQ-016 Illegal parameter values outside REQ-001 and REQ-002 SHALL stop elaboration with an error.

Reset
REQ-017 When i_reset falls to 0, all stages and o_q SHALL take RESET_VALUE immediately, without waiting for a clock edge.
REQ-018 While i_reset=0, all stages SHALL hold RESET_VALUE regardless of i_clk and i_d.
REQ-019 If i_reset rises to 1, the first rising i_clk edge after that SHALL load i_d into stage 0, and o_q SHALL leave RESET_VALUE after STAGES edges.
REQ-020 If i_reset is asserted while data is in flight, all in-flight data SHALL be discarded and SHALL never appear on o_q.
REQ-021 If i_reset rises on the same instant as a rising i_clk edge, that edge SHALL be ignored and the chain SHALL still hold RESET_VALUE.
REQ-022 After power-up and before the first reset, o_q is undefined; a bench SHALL assert reset before checking values.

Verification
REQ-023 WIDTH=1, STAGES=1: hold i_reset=0, drive i_d=1 and clock -> o_q=0; release reset, i_d=1, one edge -> o_q=1; i_d=0, one edge -> o_q=0.
REQ-024 WIDTH=1, STAGES=1: toggle i_d between edges with no rising edge -> o_q unchanged.
REQ-025 WIDTH=8, STAGES=3: drive 0x11, 0x22 and 0x33 on consecutive edges -> o_q shows 0x11 after edge 3, 0x22 after edge 4, 0x33 after edge 5.
REQ-026 WIDTH=8, STAGES=3, RESET_VALUE=0xA5: assert i_reset mid-clock-period while the pipe is full -> o_q=0xA5 immediately; after release, o_q=0xA5 for the next 2 edges.
REQ-027 Release i_reset on a rising i_clk edge -> that edge is not captured and o_q stays RESET_VALUE.
REQ-028 Randomized i_d over 1000 cycles against a STAGES-deep reference delay line -> zero mismatches.

Source files
------------

// File: rtl/dff.sv
// dff: parameterised chain of STAGES registers, WIDTH bits each, with an
// asynchronous active-low reset that forces every stage to RESET_VALUE.
// o_q comes straight from the last stage, so the i_d -> o_q latency is
// exactly STAGES rising edges and there is no combinational path to o_q.
module dff #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Reject out-of-range parameters while elaborating.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("dff: WIDTH=%0d is outside the legal range 1..64", WIDTH);
    end

    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("dff: STAGES=%0d is outside the legal range 1..16", STAGES);
    end

    // Stage 0 is nearest i_d; stage STAGES-1 drives o_q.
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Next state of the chain: stage 0 takes i_d, every later stage its predecessor.
    always_comb begin
        stage_d[0] = i_d;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Shift on each rising edge; reset clears the whole chain at once, so any
    // data still in flight when reset hits is dropped and never reaches o_q.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign o_q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff.sv
// tb_dff: drives three dff instances (1x1, 8x3 with reset value 0xA5,
// 64x16) from one clock and one reset. A queue-based model of "values
// captured since the last reset" predicts every output; a compare process
// checks all three outputs on each falling edge, and literal expectations
// pin the model at the interesting points of the sequence.
module tb_dff;

    localparam logic [7:0]  RV3  = 8'hA5;
    localparam logic [63:0] RV16 = 64'hDEAD_BEEF_0123_4567;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b1;
    logic        d1      = 1'b0;
    logic [7:0]  d3      = '0;
    logic [63:0] d16     = '0;
    logic        q1;
    logic [7:0]  q3;
    logic [63:0] q16;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    dff #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) u_s1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(d1), .o_q(q1)
    );

    dff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(RV3)) u_s3 (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(d3), .o_q(q3)
    );

    dff #(.WIDTH(64), .STAGES(16), .RESET_VALUE(RV16)) u_s16 (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(d16), .o_q(q16)
    );

    always #5 i_clk = ~i_clk;

    // Reference: per instance, the list of values accepted since the last
    // reset. Output is the entry STAGES back from the newest, or the reset
    // value while fewer than STAGES values have been accepted.
    logic [63:0] h1[$];
    logic [63:0] h3[$];
    logic [63:0] h16[$];

    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            h1.delete();
            h3.delete();
            h16.delete();
        end else begin
            h1.push_back(64'(d1));
            h3.push_back(64'(d3));
            h16.push_back(d16);
        end
    end

    function automatic logic [63:0] model_q(input logic [63:0] h[$], input int s,
                                            input logic [63:0] rv);
        if (h.size() >= s) return h[h.size() - s];
        return rv;
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endfunction

    // Compare every output against the model away from the rising edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("model_q1",  64'(q1),  model_q(h1, 1, 64'(1'b0)));
            check("model_q3",  64'(q3),  model_q(h3, 3, 64'(RV3)));
            check("model_q16", q16,      model_q(h16, 16, RV16));
        end
    end

    // Change inputs just after a falling edge, then return just after the
    // following rising edge.
    task automatic step(input logic a, input logic [7:0] b, input logic [63:0] c);
        @(negedge i_clk);
        #1;
        d1 = a; d3 = b; d16 = c;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset asserted before any clock edge.
        #1 i_reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("async_reset_q1",  64'(q1), 64'h0);
        check("async_reset_q3",  64'(q3), 64'(RV3));
        check("async_reset_q16", q16,     RV16);

        // Held in reset with data driven and clock running: outputs stay put.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hFF, '1);
            check("reset_hold_q1", 64'(q1), 64'h0);
            check("reset_hold_q3", 64'(q3), 64'(RV3));
        end

        // Release mid-period with the first words already on the inputs.
        @(negedge i_clk);
        #1;
        d1 = 1'b1; d3 = 8'h11; d16 = {$urandom, $urandom};
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check("dff1_load_one", 64'(q1), 64'h1);
        check("pipe3_edge1",   64'(q3), 64'(RV3));
        step(1'b0, 8'h22, {$urandom, $urandom});
        check("dff1_load_zero", 64'(q1), 64'h0);
        check("pipe3_edge2",    64'(q3), 64'(RV3));
        step(1'b0, 8'h33, {$urandom, $urandom});
        check("pipe3_edge3", 64'(q3), 64'h11);
        step(1'b0, 8'h44, {$urandom, $urandom});
        check("pipe3_edge4", 64'(q3), 64'h22);
        step(1'b0, 8'h55, {$urandom, $urandom});
        check("pipe3_edge5", 64'(q3), 64'h33);

        // Toggle d1 between edges and across a falling edge: q1 must hold 0.
        d1 = 1'b1; #1 d1 = 1'b0; #1 d1 = 1'b1; #1;
        check("no_edge_toggle_q1", 64'(q1), 64'h0);
        @(negedge i_clk);
        #1;
        check("falling_edge_q1", 64'(q1), 64'h0);

        // Fill the 3-deep pipe, then reset in the middle of the high phase.
        step(1'b1, 8'hC1, {$urandom, $urandom});
        step(1'b0, 8'hC2, {$urandom, $urandom});
        step(1'b1, 8'hC3, {$urandom, $urandom});
        check("pipe3_full", 64'(q3), 64'hC1);
        #1 i_reset = 1'b0;
        #1;
        check("midcycle_reset_q1",  64'(q1), 64'h0);
        check("midcycle_reset_q3",  64'(q3), 64'(RV3));
        check("midcycle_reset_q16", q16,     RV16);
        step(1'b1, 8'h77, {$urandom, $urandom});
        check("reset_hold2_q3", 64'(q3), 64'(RV3));
        step(1'b1, 8'h78, {$urandom, $urandom});
        check("reset_hold2_q1", 64'(q1), 64'h0);

        // Release: two more edges of 0xA5, then the first new word, never a C-word.
        @(negedge i_clk);
        #1;
        d3 = 8'hD1;
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check("release_edge1_q3", 64'(q3), 64'(RV3));
        step(1'b0, 8'hD2, {$urandom, $urandom});
        check("release_edge2_q3", 64'(q3), 64'(RV3));
        step(1'b0, 8'hD3, {$urandom, $urandom});
        check("release_edge3_q3", 64'(q3), 64'hD1);

        // Reset again, then release right at a rising edge: that edge samples
        // reset still asserted, so nothing is captured.
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        #1;
        d1 = 1'b1; d3 = 8'hE1; d16 = {$urandom, $urandom};
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        check("edge_release_q1", 64'(q1), 64'h0);
        check("edge_release_q3", 64'(q3), 64'(RV3));
        @(posedge i_clk);
        #1;
        check("after_edge_release_q1", 64'(q1), 64'h1);
        check("after_edge_release_q3", 64'(q3), 64'(RV3));
        step(1'b0, 8'hE2, {$urandom, $urandom});
        check("after_edge_release2_q3", 64'(q3), 64'(RV3));
        step(1'b0, 8'hE3, {$urandom, $urandom});
        check("after_edge_release3_q3", 64'(q3), 64'hE1);

        // Random data with occasional mid-period reset pulses.
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_clk);
            #1;
            d1  = 1'($urandom);
            d3  = 8'($urandom);
            d16 = {$urandom, $urandom};
            if (i_reset && $urandom_range(0, 63) == 0) begin
                #2 i_reset = 1'b0;
                #1;
                check("rand_async_q3",  64'(q3), 64'(RV3));
                check("rand_async_q16", q16,     RV16);
            end else if (!i_reset && $urandom_range(0, 3) == 0) begin
                #1 i_reset = 1'b1;
            end
        end
        i_reset = 1'b1;
        repeat (20) @(posedge i_clk);
        @(negedge i_clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
